// File: rtl/por_pkg.sv
// Shared types and helpers for the power-on reset sequencer.
package por_pkg;

    // Sequencer state; encoding is visible on state_o.
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StHold    = 2'd1,
        StStagger = 2'd2,
        StRun     = 2'd3
    } por_state_e;

    // Bits needed to count 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/por_filter.sv
// Synchroniser plus debounce for one asynchronous supply-good flag.
module por_filter
    import por_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_CYCLES = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_pgood_async,
    output logic o_pgood_filt
);

    localparam int unsigned CntW = cnt_width(FILT_CYCLES);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CntW-1:0]        r_cnt;
    logic                   r_filt;
    logic [CntW-1:0]        w_cnt_d;
    logic                   w_filt_d;
    logic                   w_sync;

    assign w_sync       = r_sync[SYNC_STAGES-1];
    assign o_pgood_filt = r_filt;

    // Count consecutive cycles the synchronised input disagrees with the flag.
    always_comb begin
        w_cnt_d  = r_cnt;
        w_filt_d = r_filt;
        if (w_sync == r_filt) begin
            w_cnt_d = '0;
        end else if (r_cnt == CntW'(FILT_CYCLES - 1)) begin
            w_filt_d = w_sync;
            w_cnt_d  = '0;
        end else begin
            w_cnt_d = r_cnt + 1'b1;
        end
    end

    // Synchroniser chain and debounce state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync <= '0;
            r_cnt  <= '0;
            r_filt <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pgood_async};
            r_cnt  <= w_cnt_d;
            r_filt <= w_filt_d;
        end
    end

endmodule

// File: rtl/por_reset_sequencer.sv
// Power-on reset sequencer: filters supply-good flags, holds reset, releases
// domain resets in a staggered order and logs brownouts.
module por_reset_sequencer
    import por_pkg::*;
#(
    parameter int unsigned N_SUPPLY       = 2,
    parameter int unsigned N_DOMAIN       = 3,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned FILT_CYCLES    = 4,
    parameter int unsigned HOLD_CYCLES    = 2000,
    parameter int unsigned STAGGER_CYCLES = 16,
    parameter int unsigned BOD_CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [N_SUPPLY-1:0]  pgood_async,
    input  logic                 sw_rst_req,
    input  logic                 bod_clr,
    output logic [N_DOMAIN-1:0]  rst_dom_n,
    output logic                 por,
    output logic                 porb,
    output logic                 powergood,
    output logic                 bod_flag,
    output logic [BOD_CNT_W-1:0] bod_count,
    output logic [1:0]           state_o
);

    localparam int unsigned CntW = cnt_width(max_u(HOLD_CYCLES, STAGGER_CYCLES));
    localparam int unsigned DomW = cnt_width(N_DOMAIN);

    logic [N_SUPPLY-1:0]  w_pgood_filt;
    logic                 w_all_good;
    logic                 w_abort;
    logic                 w_brownout;
    logic                 w_hold_done;
    logic                 w_stag_done;
    logic                 w_last_dom;

    por_state_e           r_state;
    por_state_e           w_state_d;
    logic [CntW-1:0]      r_cnt;
    logic [CntW-1:0]      w_cnt_d;
    logic [DomW-1:0]      r_dom;
    logic [DomW-1:0]      w_dom_d;
    logic [N_DOMAIN-1:0]  r_rst_dom_n;
    logic [N_DOMAIN-1:0]  w_rst_dom_n_d;
    logic                 r_por;
    logic                 w_por_d;
    logic                 r_porb;
    logic                 r_powergood;
    logic                 w_powergood_d;
    logic                 r_bod_flag;
    logic                 w_bod_flag_d;
    logic [BOD_CNT_W-1:0] r_bod_count;
    logic [BOD_CNT_W-1:0] w_bod_count_d;

    for (genvar g = 0; g < N_SUPPLY; g++) begin : g_filt
        por_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_CYCLES (FILT_CYCLES)
        ) u_filt (
            .clk           (clk),
            .resetn        (resetn),
            .i_pgood_async (pgood_async[g]),
            .o_pgood_filt  (w_pgood_filt[g])
        );
    end

    assign w_all_good  = &w_pgood_filt;
    // Supply loss takes priority over a software request in the same cycle.
    assign w_abort     = (r_state != StIdle) && (!w_all_good || sw_rst_req);
    assign w_brownout  = (r_state == StRun) && !w_all_good;
    assign w_hold_done = (r_cnt == CntW'(HOLD_CYCLES - 1));
    assign w_stag_done = (r_cnt == CntW'(STAGGER_CYCLES - 1));
    assign w_last_dom  = (r_dom == DomW'(N_DOMAIN - 1));

    assign rst_dom_n = r_rst_dom_n;
    assign por       = r_por;
    assign porb      = r_porb;
    assign powergood = r_powergood;
    assign bod_flag  = r_bod_flag;
    assign bod_count = r_bod_count;
    assign state_o   = r_state;

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:    if (w_all_good) w_state_d = StHold;
            StHold: begin
                if (w_abort) w_state_d = StIdle;
                else if (w_hold_done) w_state_d = (N_DOMAIN == 1) ? StRun : StStagger;
            end
            StStagger: begin
                if (w_abort) w_state_d = StIdle;
                else if (w_stag_done && w_last_dom) w_state_d = StRun;
            end
            StRun:     if (w_abort) w_state_d = StIdle;
            default:   w_state_d = StIdle;
        endcase
    end

    // Next values for counters, reset outputs and brownout log.
    always_comb begin
        w_cnt_d       = r_cnt;
        w_dom_d       = r_dom;
        w_rst_dom_n_d = r_rst_dom_n;
        w_por_d       = r_por;
        w_powergood_d = r_powergood;
        w_bod_flag_d  = r_bod_flag;
        w_bod_count_d = r_bod_count;

        if (bod_clr) begin
            w_bod_flag_d  = 1'b0;
            w_bod_count_d = '0;
        end
        if (w_brownout) begin
            w_bod_flag_d = 1'b1;
            if (bod_clr) w_bod_count_d = BOD_CNT_W'(1);
            else if (r_bod_count != '1) w_bod_count_d = r_bod_count + 1'b1;
        end

        if (w_abort) begin
            w_cnt_d       = '0;
            w_dom_d       = '0;
            w_rst_dom_n_d = '0;
            w_por_d       = 1'b1;
            w_powergood_d = 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    w_cnt_d = '0;
                    w_dom_d = '0;
                end
                StHold: begin
                    if (w_hold_done) begin
                        w_cnt_d          = '0;
                        w_dom_d          = DomW'(1);
                        w_rst_dom_n_d[0] = 1'b1;
                        if (N_DOMAIN == 1) begin
                            w_por_d       = 1'b0;
                            w_powergood_d = 1'b1;
                        end
                    end else begin
                        w_cnt_d = r_cnt + 1'b1;
                    end
                end
                StStagger: begin
                    if (w_stag_done) begin
                        w_cnt_d              = '0;
                        w_dom_d              = r_dom + 1'b1;
                        w_rst_dom_n_d[r_dom] = 1'b1;
                        if (w_last_dom) begin
                            w_por_d       = 1'b0;
                            w_powergood_d = 1'b1;
                        end
                    end else begin
                        w_cnt_d = r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt       <= '0;
            r_dom       <= '0;
            r_rst_dom_n <= '0;
            r_por       <= 1'b1;
            r_porb      <= 1'b0;
            r_powergood <= 1'b0;
            r_bod_flag  <= 1'b0;
            r_bod_count <= '0;
        end else begin
            r_cnt       <= w_cnt_d;
            r_dom       <= w_dom_d;
            r_rst_dom_n <= w_rst_dom_n_d;
            r_por       <= w_por_d;
            r_porb      <= ~w_por_d;
            r_powergood <= w_powergood_d;
            r_bod_flag  <= w_bod_flag_d;
            r_bod_count <= w_bod_count_d;
        end
    end

endmodule

// File: tb/tb_por_reset_sequencer.sv
// Directed self-checking bench for por_reset_sequencer (FILT=4, HOLD=20, STAGGER=5, 3 domains).
module tb_por_reset_sequencer;

    localparam logic [1:0] SIdle    = 2'd0;
    localparam logic [1:0] SHold    = 2'd1;
    localparam logic [1:0] SStagger = 2'd2;
    localparam logic [1:0] SRun     = 2'd3;

    logic       clk = 1'b0;
    logic       resetn;
    logic [1:0] pgood_async;
    logic       sw_rst_req;
    logic       bod_clr;
    logic [2:0] rst_dom_n;
    logic       por;
    logic       porb;
    logic       powergood;
    logic       bod_flag;
    logic [7:0] bod_count;
    logic [1:0] state_o;

    int checks   = 0;
    int failures = 0;
    int cyc;

    por_reset_sequencer #(
        .N_SUPPLY       (2),
        .N_DOMAIN       (3),
        .SYNC_STAGES    (2),
        .FILT_CYCLES    (4),
        .HOLD_CYCLES    (20),
        .STAGGER_CYCLES (5),
        .BOD_CNT_W      (8)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .pgood_async (pgood_async),
        .sw_rst_req  (sw_rst_req),
        .bod_clr     (bod_clr),
        .rst_dom_n   (rst_dom_n),
        .por         (por),
        .porb        (porb),
        .powergood   (powergood),
        .bod_flag    (bod_flag),
        .bod_count   (bod_count),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Poll on falling edges until state_o equals st; an expired budget fails the check.
    task automatic wait_state(input logic [1:0] st, input int budget, input string tag,
                              output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (state_o !== st && n < budget);
        check(tag, 32'(state_o), 32'(st));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rst"}, 32'(rst_dom_n), 32'h0);
        check({tag, "_por"}, 32'(por), 32'h1);
        check({tag, "_porb"}, 32'(porb), 32'h0);
        check({tag, "_pg"}, 32'(powergood), 32'h0);
    endtask

    // Called on the falling edge right after HOLD entry; walks the full release sequence.
    task automatic check_sequence(input string tag, input logic flag, input logic [7:0] cnt);
        repeat (19) @(negedge clk);
        check({tag, "_hold19_rst"}, 32'(rst_dom_n), 32'h0);
        check({tag, "_hold19_st"}, 32'(state_o), 32'(SHold));
        @(negedge clk);
        check({tag, "_dom0_rst"}, 32'(rst_dom_n), 32'h1);
        check({tag, "_dom0_st"}, 32'(state_o), 32'(SStagger));
        check({tag, "_dom0_por"}, 32'(por), 32'h1);
        repeat (4) @(negedge clk);
        check({tag, "_pre_dom1"}, 32'(rst_dom_n), 32'h1);
        @(negedge clk);
        check({tag, "_dom1_rst"}, 32'(rst_dom_n), 32'h3);
        repeat (4) @(negedge clk);
        check({tag, "_pre_dom2_por"}, 32'(por), 32'h1);
        @(negedge clk);
        check({tag, "_dom2_rst"}, 32'(rst_dom_n), 32'h7);
        check({tag, "_run_por"}, 32'(por), 32'h0);
        check({tag, "_run_porb"}, 32'(porb), 32'h1);
        check({tag, "_run_pg"}, 32'(powergood), 32'h1);
        check({tag, "_run_st"}, 32'(state_o), 32'(SRun));
        check({tag, "_run_flag"}, 32'(bod_flag), 32'(flag));
        check({tag, "_run_cnt"}, 32'(bod_count), 32'(cnt));
    endtask

    initial begin
        resetn      = 1'b0;
        pgood_async = 2'b00;
        sw_rst_req  = 1'b0;
        bod_clr     = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values.
        check_reset_outputs("reset");
        check("reset_flag", 32'(bod_flag), 32'h0);
        check("reset_cnt", 32'(bod_count), 32'h0);
        check("reset_st", 32'(state_o), 32'(SIdle));
        resetn = 1'b1;
        @(negedge clk);

        // Software request is ignored in IDLE.
        sw_rst_req = 1'b1;
        @(negedge clk);
        sw_rst_req = 1'b0;
        check("sw_idle_st", 32'(state_o), 32'(SIdle));

        // 1. Power-up: 2 sync + 4 filter cycles, then one more to enter HOLD.
        pgood_async = 2'b11;
        wait_state(SHold, 30, "pu_hold", cyc);
        check("pu_latency", 32'(cyc), 32'd7);
        check_sequence("pu", 1'b0, 8'd0);

        // 2. Three-cycle glitch on supply 1 is filtered out.
        pgood_async = 2'b01;
        repeat (3) @(negedge clk);
        pgood_async = 2'b11;
        repeat (10) @(negedge clk);
        check("glitch_st", 32'(state_o), 32'(SRun));
        check("glitch_rst", 32'(rst_dom_n), 32'h7);
        check("glitch_cnt", 32'(bod_count), 32'h0);
        check("glitch_flag", 32'(bod_flag), 32'h0);

        // 3. Six-cycle loss of supply 0 is a brownout.
        pgood_async = 2'b10;
        repeat (6) @(negedge clk);
        check("bo_pre_st", 32'(state_o), 32'(SRun));
        pgood_async = 2'b11;
        @(negedge clk);
        check("bo_st", 32'(state_o), 32'(SIdle));
        check_reset_outputs("bo");
        check("bo_flag", 32'(bod_flag), 32'h1);
        check("bo_cnt", 32'(bod_count), 32'h1);
        wait_state(SHold, 20, "bo_rehold", cyc);
        check_sequence("bo_seq", 1'b1, 8'd1);

        // 5a. Software reset in RUN leaves the brownout log alone.
        sw_rst_req = 1'b1;
        @(negedge clk);
        sw_rst_req = 1'b0;
        check("sw_st", 32'(state_o), 32'(SIdle));
        check_reset_outputs("sw");
        check("sw_flag", 32'(bod_flag), 32'h1);
        check("sw_cnt", 32'(bod_count), 32'h1);
        wait_state(SHold, 5, "sw_rehold", cyc);
        check_sequence("sw_seq", 1'b1, 8'd1);

        bod_clr = 1'b1;
        @(negedge clk);
        bod_clr = 1'b0;
        check("clr_flag", 32'(bod_flag), 32'h0);
        check("clr_cnt", 32'(bod_count), 32'h0);
        check("clr_st", 32'(state_o), 32'(SRun));

        // 4. Supply loss part-way through HOLD is a retry, not a brownout.
        sw_rst_req = 1'b1;
        @(negedge clk);
        sw_rst_req = 1'b0;
        wait_state(SHold, 5, "ab_hold", cyc);
        repeat (4) @(negedge clk);
        pgood_async = 2'b01;
        wait_state(SIdle, 20, "ab_idle", cyc);
        check_reset_outputs("ab");
        check("ab_flag", 32'(bod_flag), 32'h0);
        check("ab_cnt", 32'(bod_count), 32'h0);
        pgood_async = 2'b11;
        wait_state(SHold, 20, "ab_rehold", cyc);
        check_sequence("ab_seq", 1'b0, 8'd0);

        // 6. Counter saturates at 255.
        for (int i = 0; i < 260; i++) begin
            pgood_async = 2'b10;
            wait_state(SIdle, 20, "sat_idle", cyc);
            pgood_async = 2'b11;
            wait_state(SRun, 60, "sat_run", cyc);
        end
        check("sat_cnt", 32'(bod_count), 32'd255);
        check("sat_flag", 32'(bod_flag), 32'h1);

        // 5b. Clear in the same cycle as a brownout: the new event wins.
        pgood_async = 2'b10;
        repeat (6) @(negedge clk);
        bod_clr = 1'b1;
        @(negedge clk);
        bod_clr = 1'b0;
        check("clrbo_st", 32'(state_o), 32'(SIdle));
        check("clrbo_flag", 32'(bod_flag), 32'h1);
        check("clrbo_cnt", 32'(bod_count), 32'h1);

        // 6. Asynchronous reset mid-STAGGER takes effect without a clock edge.
        pgood_async = 2'b11;
        wait_state(SStagger, 40, "ar_stag", cyc);
        repeat (2) @(negedge clk);
        check("ar_pre_rst", 32'(rst_dom_n), 32'h1);
        resetn = 1'b0;
        #1;
        check_reset_outputs("ar");
        check("ar_flag", 32'(bod_flag), 32'h0);
        check("ar_cnt", 32'(bod_count), 32'h0);
        check("ar_st", 32'(state_o), 32'(SIdle));
        @(negedge clk);
        resetn = 1'b1;
        wait_state(SHold, 30, "ar_rehold", cyc);
        check("ar_latency", 32'(cyc), 32'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
